// File: rtl/sprite_line_engine_if.sv
// rtl/sprite_line_engine_if.sv - sprite memory read port (engine is master, memory is slave)
interface sprite_line_engine_if #(
    parameter int ADDRW = 10,
    parameter int COLRW = 4
) ();
    logic             mem_rd;
    logic [ADDRW-1:0] mem_addr;
    logic [COLRW-1:0] mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/sprite_line_engine.sv
// rtl/sprite_line_engine.sv - single sprite row fetch + pixel output; SPRITE_TRANSP_EN enables transparency
module sprite_line_engine #(
    parameter int               CORDW       = 11,
    parameter int               SPR_WIDTH   = 32,
    parameter int               SPR_HEIGHT  = 32,
    parameter int               COLRW       = 4,
    parameter int               SCALE_SHIFT = 0,
    parameter logic [COLRW-1:0] TRANSP_COLR = '0,
    parameter int               ADDRW       = $clog2(SPR_WIDTH*SPR_HEIGHT)
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    sprite_line_engine_if.master    mem,
    output logic [COLRW-1:0]        pix,
    output logic                    drawing,
    output logic                    busy
);

`ifdef SPRITE_TRANSP_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    localparam int CW   = (SPR_WIDTH > 1) ? $clog2(SPR_WIDTH) : 1;
    localparam int CNTW = $clog2(SPR_WIDTH + 1);
    localparam int RW   = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;
    localparam logic signed [CORDW:0] WLIM = (CORDW+1)'(SPR_WIDTH << SCALE_SHIFT);
    localparam logic signed [CORDW:0] HLIM = (CORDW+1)'(SPR_HEIGHT << SCALE_SHIFT);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FETCH, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic signed [CORDW-1:0] sy_l, sprx_l, spry_l;
    logic [RW-1:0]           row_q;
    logic [CNTW-1:0]         col_q;
    logic                    buf_valid_q;
    logic                    mem_rd_q;
    logic [ADDRW-1:0]        mem_addr_q;
    logic [CW-1:0]           wcol_q;
    logic                    rd_d_q;
    logic [CW-1:0]           wcol_d_q;
    logic [COLRW-1:0]        pix_q;
    logic                    drawing_q;
    logic [COLRW-1:0]        line_buf [SPR_WIDTH];

    logic signed [CORDW:0]   roff;
    logic                    row_hit;
    logic                    issue;
    logic [ADDRW-1:0]        addr_next;
    logic signed [CORDW:0]   dx;
    logic                    in_range;
    logic [COLRW-1:0]        texel;
    logic                    hide;

    assign roff      = {sy_l[CORDW-1], sy_l} - {spry_l[CORDW-1], spry_l};
    assign row_hit   = !roff[CORDW] && (roff < HLIM);
    assign addr_next = ADDRW'(row_q) * ADDRW'(SPR_WIDTH) + ADDRW'(col_q);

    assign dx        = {sx[CORDW-1], sx} - {sprx_l[CORDW-1], sprx_l};
    assign in_range  = buf_valid_q && !sx[CORDW-1] && !dx[CORDW] && (dx < WLIM);
    assign texel     = line_buf[CW'(dx >> SCALE_SHIFT)];
    assign hide      = TRANSP_EN && (texel == TRANSP_COLR);

    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = mem_addr_q;
    assign pix          = pix_q;
    assign drawing      = drawing_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_DRAIN);

    // state register
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // next state; FETCH lingers one cycle after the last issue so DRAIN lines up with the final texel
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (line) begin
            state_d = S_CALC;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_CALC:  state_d = row_hit ? S_FETCH : S_IDLE;
                S_FETCH: begin
                    if (col_q == CNTW'(SPR_WIDTH)) state_d = S_DRAIN;
                    else                           issue   = 1'b1;
                end
                S_DRAIN: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // fetch datapath: latch line parameters, issue addresses, track write column through memory latency
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sy_l        <= '0;
            sprx_l      <= '0;
            spry_l      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            buf_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            wcol_q      <= '0;
            rd_d_q      <= 1'b0;
            wcol_d_q    <= '0;
        end else if (line) begin
            sy_l        <= sy;
            sprx_l      <= sprx;
            spry_l      <= spry;
            col_q       <= '0;
            buf_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            rd_d_q      <= 1'b0;
        end else begin
            if (state_q == S_CALC && row_hit) begin
                row_q <= RW'(roff >> SCALE_SHIFT);
                col_q <= '0;
            end
            mem_rd_q <= issue;
            if (issue) begin
                mem_addr_q <= addr_next;
                wcol_q     <= CW'(col_q);
                col_q      <= col_q + CNTW'(1);
            end
            rd_d_q   <= mem_rd_q;
            wcol_d_q <= wcol_q;
            if (state_q == S_DRAIN) buf_valid_q <= 1'b1;
        end
    end

    // line buffer write: texel arrives the cycle after the memory samples its address
    always_ff @(posedge clk_pix) begin
        if (rd_d_q) line_buf[wcol_d_q] <= mem.mem_data;
    end

    // registered pixel output
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            pix_q     <= '0;
            drawing_q <= 1'b0;
        end else begin
            drawing_q <= in_range && !hide;
            pix_q     <= (in_range && !hide) ? texel : '0;
        end
    end

endmodule
